// File: rtl/chunked_adder_ctrl.sv
// rtl/chunked_adder_ctrl.sv - WIDTH-bit add time-shared over one CHUNK-bit ripple adder.
// Define CHUNKED_ADDER_OVF_EN to add the o_overflow signed-overflow output.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module chunked_adder_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_data0,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             o_overflow
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (CHUNK <= 0 || WIDTH <= 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_adder_ctrl: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_load;
  logic   w_step;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic [OW-1:0]    w_off;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic [CHUNK:0]   w_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = !i_rst;
        if (i_valid) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_k == K_LAST) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        if (i_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The single shared adder: chunk k of each operand plus the running carry.
  assign w_off     = OW'(int'(r_k) * CHUNK);
  assign w_a_chunk = r_a[w_off +: CHUNK];
  assign w_b_chunk = r_b[w_off +: CHUNK];
  assign w_c[0]    = r_c;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .i_a   (w_a_chunk[i]),
      .i_b   (w_b_chunk[i]),
      .i_cin (w_c[i]),
      .o_sum (w_sum_chunk[i]),
      .o_cout(w_c[i+1])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      if (w_load) begin
        r_a <= i_data0;
        r_b <= i_data1;
        r_c <= i_carry;
        r_k <= '0;
      end
      if (w_step) begin
        r_sum[w_off +: CHUNK] <= w_sum_chunk;
        r_c                   <= w_c[CHUNK];
        if (r_k == K_LAST) begin
          r_carry <= w_c[CHUNK];
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_carry = r_carry;

`ifdef CHUNKED_ADDER_OVF_EN
  logic r_ovf;

  // Sign bits of A, B and the sum all live in the last chunk.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (w_step && (r_k == K_LAST)) begin
      r_ovf <= (w_a_chunk[CHUNK-1] == w_b_chunk[CHUNK-1]) &&
               (w_sum_chunk[CHUNK-1] != w_a_chunk[CHUNK-1]);
    end
  end

  assign o_overflow = r_ovf;
`endif

endmodule

// File: tb/tb_chunked_adder_ctrl.sv
// tb/tb_chunked_adder_ctrl.sv - scoreboard bench for chunked_adder_ctrl.
module tb_chunked_adder_ctrl;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             in_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  chunked_adder_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_carry   (cin),
    .i_data0   (a),
    .i_data1   (b),
    .o_valid   (out_valid),
    .i_ready   (in_ready),
    .o_sum     (sum),
    .o_carry   (cout)
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    .o_overflow(ovf)
`endif
  );

`ifndef CHUNKED_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    exp_t e;
    logic [WIDTH:0] full;
    full    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    e.sum   = full[WIDTH-1:0];
    e.carry = full[WIDTH];
    e.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || out_ready !== 1'b0 || ovf !== 1'b0)
        $display("FAIL reset_outputs cyc=%0d got valid=%b sum=%h carry=%b ready=%b ovf=%b want 0/0/0/0/0",
                 i, out_valid, sum, cout, out_ready, ovf);
      else passed++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", out_ready);
    else passed++;
  endtask

  // Issue one operation, optionally scrambling inputs during RUN, then hold DONE for hold cycles.
  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input bit toggle, input int hold);
    int   cyc;
    bit   got;
    exp_t e;
    a = x; b = y; cin = c; in_valid = 1'b1;
    checks++;
    if (out_ready !== 1'b1) $display("FAIL %s accept_ready got %b want 1", name, out_ready);
    else passed++;
    exp_q.push_back(model(x, y, c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s run_flags got ready=%b valid=%b want 0/0", name, out_ready, out_valid);
    else passed++;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (toggle) begin
        in_valid = 1'($urandom);
        a = $urandom; b = $urandom; cin = 1'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (!got || cyc != N) $display("FAIL %s latency got %0d (seen=%0d) want %0d", name, cyc, got, N);
    else passed++;
    if (!got) return;
    checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard_empty got 0 entries want 1", name);
      return;
    end
    e = exp_q.pop_front();
    if (sum !== e.sum || cout !== e.carry || ovf !== (e.ovf & dut_has_ovf()))
      $display("FAIL %s result got sum=%h carry=%b ovf=%b want sum=%h carry=%b ovf=%b",
               name, sum, cout, ovf, e.sum, e.carry, e.ovf & dut_has_ovf());
    else passed++;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_ready !== 1'b0 || sum !== e.sum || cout !== e.carry)
        $display("FAIL %s hold cyc=%0d got valid=%b ready=%b sum=%h carry=%b want 1/0/%h/%b",
                 name, h, out_valid, out_ready, sum, cout, e.sum, e.carry);
      else passed++;
    end
    in_ready = 1'b1;
    @(posedge clk); #1;
    in_ready = 1'b0;
    checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b0 || sum !== e.sum)
      $display("FAIL %s release got ready=%b valid=%b sum=%h want 1/0/%h",
               name, out_ready, out_valid, sum, e.sum);
    else passed++;
  endtask

  function automatic logic dut_has_ovf();
`ifdef CHUNKED_ADDER_OVF_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_basic();
    run_op("basic_ff_plus_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("full_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpressure", 32'h1234_5678, 32'h89AB_CDEF, 1'b1, 1'b1, 5);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op("random", $urandom, $urandom, 1'($urandom), 1'b0, i % 2);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    a = 32'h0101_0101; b = 32'h0202_0202; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || out_ready !== 1'b0 || ovf !== 1'b0)
      $display("FAIL midrun_reset got valid=%b sum=%h carry=%b ready=%b ovf=%b want 0/0/0/0/0",
               out_valid, sum, cout, out_ready, ovf);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (out_ready !== 1'b1) $display("FAIL midrun_idle_ready got %b want 1", out_ready);
    else passed++;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) $display("FAIL midrun_no_valid got %0d pulses want 0", pulses);
    else passed++;
    run_op("after_reset_1_plus_2", 32'h1, 32'h2, 1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
